// File: rtl/system_bus_ctrl.sv
// -----------------------------------------------------------------------------
// system_bus_ctrl
//
// Control unit for a small accumulator CPU. It sequences instruction fetch,
// operand fetch and execute over a shared system bus. It also waits on a
// memory handshake and gives up with a bus error if memory stalls too long.
//
// Parameters
//   TIMEOUT   maximum number of stalled cycles tolerated in a memory wait
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   opcode    IR opcode field, meaningful from DEC onward
//   z_flag    accumulator-zero flag (conditional jump)
//   mem_ready memory completes the current read/write this cycle
//   bus_sel   system bus mux select: 0 PCBUS, 1 DRBUS, 2 MEMBUS
//   ar_ld, pc_ld, pc_inc, dr_ld, ir_ld, ac_ld, mem_rd, mem_wr
//             register / memory strobes
//   alu_op    0 PASS, 1 ADD, 2 AND
//   halted    HALT executed, held until reset
//   bus_err   memory wait timed out, held until reset
// -----------------------------------------------------------------------------
module system_bus_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       z_flag,
    input  logic       mem_ready,
    output logic [1:0] bus_sel,
    output logic       ar_ld,
    output logic       pc_ld,
    output logic       pc_inc,
    output logic       dr_ld,
    output logic       ir_ld,
    output logic       ac_ld,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       bus_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [3:0] OPC_NOP  = 4'd0;
    localparam logic [3:0] OPC_LDAC = 4'd1;
    localparam logic [3:0] OPC_STAC = 4'd2;
    localparam logic [3:0] OPC_ADD  = 4'd3;
    localparam logic [3:0] OPC_AND  = 4'd4;
    localparam logic [3:0] OPC_JUMP = 4'd5;
    localparam logic [3:0] OPC_JMPZ = 4'd6;
    localparam logic [3:0] OPC_HALT = 4'd7;

    typedef enum logic [3:0] {
        F1, F2, DEC, OP1, OP2, OP3, EX1, EX2, ST1, HLT, ERR
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic            timed_out;

    assign timed_out = (wait_cnt_reg == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= F1;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        bus_sel       = 2'd0;
        ar_ld         = 1'b0;
        pc_ld         = 1'b0;
        pc_inc        = 1'b0;
        dr_ld         = 1'b0;
        ir_ld         = 1'b0;
        ac_ld         = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        alu_op        = 2'd0;
        halted        = 1'b0;
        bus_err       = 1'b0;

        // Decode is gated by rst_n so nothing leaks out of the F1 decode
        // while reset is held low.
        if (rst_n) begin
            unique case (state_reg)
                F1, OP1: begin
                    bus_sel    = 2'd0;
                    ar_ld      = 1'b1;
                    state_next = (state_reg == F1) ? F2 : OP2;
                end
                F2, OP2, EX1: begin
                    bus_sel = 2'd2;
                    mem_rd  = 1'b1;
                    if (mem_ready) begin
                        dr_ld  = 1'b1;
                        ir_ld  = (state_reg == F2);
                        pc_inc = (state_reg != EX1);
                        state_next = (state_reg == F2)  ? DEC :
                                     (state_reg == OP2) ? OP3 : EX2;
                    end else if (timed_out) begin
                        state_next = ERR;
                    end
                end
                DEC: begin
                    if (opcode == OPC_NOP || opcode[3])
                        state_next = F1;
                    else if (opcode == OPC_HALT)
                        state_next = HLT;
                    else
                        state_next = OP1;
                end
                OP3: begin
                    bus_sel    = 2'd1;
                    state_next = F1;
                    case (opcode)
                        OPC_JUMP: pc_ld = 1'b1;
                        OPC_JMPZ: pc_ld = z_flag;
                        OPC_LDAC, OPC_ADD, OPC_AND: begin
                            ar_ld      = 1'b1;
                            state_next = EX1;
                        end
                        OPC_STAC: begin
                            ar_ld      = 1'b1;
                            state_next = ST1;
                        end
                        default: state_next = F1;
                    endcase
                end
                EX2: begin
                    bus_sel    = 2'd1;
                    ac_ld      = 1'b1;
                    alu_op     = (opcode == OPC_ADD) ? 2'd1 :
                                 (opcode == OPC_AND) ? 2'd2 : 2'd0;
                    state_next = F1;
                end
                ST1: begin
                    bus_sel = 2'd0;
                    mem_wr  = 1'b1;
                    if (mem_ready)
                        state_next = F1;
                    else if (timed_out)
                        state_next = ERR;
                end
                HLT: halted  = 1'b1;
                ERR: bus_err = 1'b1;
                default: state_next = F1;
            endcase

            // Count stalled cycles in the memory-wait states, saturating.
            if ((state_reg == F2 || state_reg == OP2 || state_reg == EX1 ||
                 state_reg == ST1) && !mem_ready && wait_cnt_reg != '1)
                wait_cnt_next = wait_cnt_reg + CW'(1);

            // Any state change starts the next wait from zero.
            if (state_next != state_reg)
                wait_cnt_next = '0;
        end
    end

endmodule
